// File: rtl/hrm_sequencer_pkg.sv
// Shared encodings for the HRM sequencer: opcodes, FSM states, accumulator source and ALU op codes.
// The INDIR state only exists when HRM_INDIRECT_EN is defined.
package hrm_sequencer_pkg;

  localparam logic [3:0] OP_INBOX    = 4'h0;
  localparam logic [3:0] OP_OUTBOX   = 4'h1;
  localparam logic [3:0] OP_COPYFROM = 4'h2;
  localparam logic [3:0] OP_COPYTO   = 4'h3;
  localparam logic [3:0] OP_ADD      = 4'h4;
  localparam logic [3:0] OP_SUB      = 4'h5;
  localparam logic [3:0] OP_BUMPP    = 4'h6;
  localparam logic [3:0] OP_BUMPM    = 4'h7;
  localparam logic [3:0] OP_JUMP     = 4'h8;
  localparam logic [3:0] OP_JUMPZ    = 4'h9;
  localparam logic [3:0] OP_JUMPN    = 4'hA;

  localparam logic [7:0] HALT_OP_DEFAULT = 8'hF0;

  localparam logic [1:0] SRC_INBOX = 2'd0;
  localparam logic [1:0] SRC_MEM   = 2'd1;
  localparam logic [1:0] SRC_ALU   = 2'd2;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_INC = 2'd2;
  localparam logic [1:0] ALU_DEC = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_ARG    = 3'd2,
`ifdef HRM_INDIRECT_EN
    S_INDIR  = 3'd3,
`endif
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_INBOX, CLS_OUTBOX, CLS_COPYFROM, CLS_COPYTO,
    CLS_ADD, CLS_SUB, CLS_BUMPP, CLS_BUMPM,
    CLS_JUMP, CLS_JUMPZ, CLS_JUMPN, CLS_HALT, CLS_ILLEGAL
  } opclass_t;

endpackage

// File: rtl/hrm_opdec.sv
// Combinational instruction decode: rIR -> opcode class, operand/indirect/legal flags.
// Zero latency; no handshake. Indirect flag is forced low unless HRM_INDIRECT_EN is defined.
module hrm_opdec
  import hrm_sequencer_pkg::*;
#(
  parameter logic [7:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic [7:0] i_ir,
  output logic       o_has_operand,
  output logic       o_is_indirect,
  output logic       o_is_legal,
  output opclass_t   o_opclass
);

  always_comb begin
    o_opclass  = CLS_ILLEGAL;
    o_is_legal = 1'b1;
    // The full halt byte wins over any nibble match so HALT_OP can be reassigned freely.
    if (i_ir == HALT_OP) begin
      o_opclass = CLS_HALT;
    end else begin
      case (i_ir[7:4])
        OP_INBOX:    o_opclass = CLS_INBOX;
        OP_OUTBOX:   o_opclass = CLS_OUTBOX;
        OP_COPYFROM: o_opclass = CLS_COPYFROM;
        OP_COPYTO:   o_opclass = CLS_COPYTO;
        OP_ADD:      o_opclass = CLS_ADD;
        OP_SUB:      o_opclass = CLS_SUB;
        OP_BUMPP:    o_opclass = CLS_BUMPP;
        OP_BUMPM:    o_opclass = CLS_BUMPM;
        OP_JUMP:     o_opclass = CLS_JUMP;
        OP_JUMPZ:    o_opclass = CLS_JUMPZ;
        OP_JUMPN:    o_opclass = CLS_JUMPN;
        default:     o_is_legal = 1'b0;
      endcase
    end
  end

  assign o_has_operand = o_is_legal && (o_opclass != CLS_INBOX) &&
                         (o_opclass != CLS_OUTBOX) && (o_opclass != CLS_HALT);

`ifdef HRM_INDIRECT_EN
  assign o_is_indirect = o_has_operand & i_ir[3];
`else
  assign o_is_indirect = 1'b0;
`endif

endmodule

// File: rtl/hrm_sequencer.sv
// HRM control sequencer: FETCH/DECODE/ARG/(INDIR)/EXEC/HALT, strobes decoded from state and rIR.
// EXEC stalls on inbox_empty/outbox_full; HRM_INDIRECT_EN adds the INDIR operand-deref state.
module hrm_sequencer
  import hrm_sequencer_pkg::*;
#(
  parameter logic [7:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rIR,
  input  logic       aluZ,
  input  logic       aluN,
  input  logic       inbox_empty,
  input  logic       outbox_full,
  output logic       wIR,
  output logic       wPC,
  output logic       jmp,
  output logic       wAR,
  output logic       wM,
  output logic       wR,
  output logic [1:0] srcR,
  output logic [1:0] alu_op,
  output logic       rInbox,
  output logic       wOutbox,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] state
);

  state_t   r_state, w_next;
  logic     r_halted, r_illegal;
  logic     w_has_operand, w_is_indirect, w_is_legal;
  opclass_t w_opclass;
  logic     w_wir, w_wpc, w_jmp, w_war, w_wm, w_wr, w_rinbox, w_woutbox;
  logic [1:0] w_srcr, w_aluop;

  hrm_opdec #(.HALT_OP(HALT_OP)) u_opdec (
    .i_ir          (rIR),
    .o_has_operand (w_has_operand),
    .o_is_indirect (w_is_indirect),
    .o_is_legal    (w_is_legal),
    .o_opclass     (w_opclass)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_HALT) r_halted <= 1'b1;
      if (r_state == S_DECODE && !w_is_legal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_wir     = 1'b0;
    w_wpc     = 1'b0;
    w_jmp     = 1'b0;
    w_war     = 1'b0;
    w_wm      = 1'b0;
    w_wr      = 1'b0;
    w_srcr    = SRC_INBOX;
    w_aluop   = ALU_ADD;
    w_rinbox  = 1'b0;
    w_woutbox = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_wir  = 1'b1;
        w_wpc  = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (!w_is_legal || w_opclass == CLS_HALT) w_next = S_HALT;
        else if (w_has_operand)                   w_next = S_ARG;
        else                                      w_next = S_EXEC;
      end
      S_ARG: begin
        w_war = 1'b1;
        w_wpc = 1'b1;
`ifdef HRM_INDIRECT_EN
        w_next = w_is_indirect ? S_INDIR : S_EXEC;
`else
        w_next = S_EXEC;
`endif
      end
`ifdef HRM_INDIRECT_EN
      S_INDIR: begin
        w_war  = 1'b1;
        w_next = S_EXEC;
      end
`endif
      S_EXEC: begin
        w_next = S_FETCH;
        case (w_opclass)
          // I/O ops hold EXEC with all strobes low until their queue is ready.
          CLS_INBOX: begin
            if (inbox_empty) w_next = S_EXEC;
            else begin
              w_rinbox = 1'b1;
              w_wr     = 1'b1;
              w_srcr   = SRC_INBOX;
            end
          end
          CLS_OUTBOX: begin
            if (outbox_full) w_next = S_EXEC;
            else             w_woutbox = 1'b1;
          end
          CLS_COPYFROM: begin w_wr = 1'b1; w_srcr = SRC_MEM; end
          CLS_COPYTO:   w_wm = 1'b1;
          CLS_ADD:   begin w_wr = 1'b1; w_srcr = SRC_ALU; w_aluop = ALU_ADD; end
          CLS_SUB:   begin w_wr = 1'b1; w_srcr = SRC_ALU; w_aluop = ALU_SUB; end
          CLS_BUMPP: begin w_wr = 1'b1; w_wm = 1'b1; w_srcr = SRC_ALU; w_aluop = ALU_INC; end
          CLS_BUMPM: begin w_wr = 1'b1; w_wm = 1'b1; w_srcr = SRC_ALU; w_aluop = ALU_DEC; end
          CLS_JUMP:  begin w_wpc = 1'b1; w_jmp = 1'b1; end
          CLS_JUMPZ: begin w_wpc = aluZ; w_jmp = aluZ; end
          CLS_JUMPN: begin w_wpc = aluN; w_jmp = aluN; end
          default:   w_next = S_HALT;
        endcase
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // Outputs are forced quiet during rst so an aborted EXEC never leaks a write.
  assign wIR     = w_wir     & ~rst;
  assign wPC     = w_wpc     & ~rst;
  assign jmp     = w_jmp     & ~rst;
  assign wAR     = w_war     & ~rst;
  assign wM      = w_wm      & ~rst;
  assign wR      = w_wr      & ~rst;
  assign srcR    = rst ? 2'b00 : w_srcr;
  assign alu_op  = rst ? 2'b00 : w_aluop;
  assign rInbox  = w_rinbox  & ~rst;
  assign wOutbox = w_woutbox & ~rst;
  assign halted  = r_halted  & ~rst;
  assign illegal = r_illegal & ~rst;
  assign state   = rst ? S_FETCH : r_state;

endmodule

// File: doc/hrm_sequencer.md
HRM_SEQUENCER -- requirements
Module: hrm_sequencer

Interface
REQ-001 Parameter: HALT_OP, 8'hF0, opcode byte that stops the sequencer.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rIR  in  8  instruction register contents: opcode in [7:4], indirect bit in [3].
REQ-005 aluZ / aluN  in  1 each  accumulator zero / negative flags.
REQ-006 inbox_empty / outbox_full  in  1 each  I/O queue status.
REQ-007 wIR  out  1  load instruction register from program memory data.
REQ-008 wPC  out  1  PC update enable; jmp  out  1  PC source, 1=AR, 0=PC+1.
REQ-009 wAR  out  1  load address register from program or data memory.
REQ-010 wM  out  1  data memory write; wR  out  1  accumulator write.
REQ-011 srcR  out  2  accumulator source: 0 inbox, 1 memory, 2 ALU, 3 reserved.
REQ-012 alu_op  out  2  ALU operation: 0 add, 1 sub, 2 inc, 3 dec.
REQ-013 rInbox / wOutbox  out  1 each  single-cycle dequeue / enqueue strobes.
REQ-014 halted / illegal  out  1 each  sticky status; state  out  3  debug state code.

Function
REQ-015 The FSM SHALL have states FETCH, DECODE, ARG, INDIR, EXEC, HALT.
REQ-016 FETCH SHALL assert wIR=1 and wPC=1 with jmp=0 for one cycle, then go to DECODE.
REQ-017 In DECODE, opcodes 0x0 inbox, 0x1 outbox and HALT_OP SHALL go straight to EXEC or HALT. All other defined opcodes take an operand and go to ARG.
REQ-018 ARG SHALL assert wAR=1 and wPC=1 with jmp=0 for one cycle. The next state is INDIR when rIR[3]=1, otherwise EXEC.
REQ-019 INDIR SHALL assert wAR=1 for one cycle, loading AR from data memory, then go to EXEC.
REQ-020 Opcode 0x0 inbox: while inbox_empty=1, EXEC SHALL hold with all strobes low. On the first cycle with inbox_empty=0, EXEC SHALL assert rInbox=1, wR=1, srcR=0, then go to FETCH.
REQ-021 Opcode 0x1 outbox: while outbox_full=1, EXEC SHALL hold with all strobes low. On the first cycle with outbox_full=0, EXEC SHALL assert wOutbox=1 for one cycle, then go to FETCH.
REQ-022 Opcode 0x2 copyfrom SHALL assert wR=1 with srcR=1. Opcode 0x3 copyto SHALL assert wM=1.
REQ-023 Opcodes 0x4 add and 0x5 sub SHALL assert wR=1, srcR=2, alu_op=0 or 1 respectively.
REQ-024 Opcodes 0x6 bump+ and 0x7 bump- SHALL assert wR=1, wM=1, srcR=2, alu_op=2 or 3 respectively.
REQ-025 Opcode 0x8 jump SHALL assert wPC=1, jmp=1.
REQ-026 Opcodes 0x9 jumpz and 0xA jumpn SHALL assert wPC=1, jmp=1 only when aluZ=1 or aluN=1 respectively; otherwise no strobe.
REQ-027 Each EXEC in REQ-022 to REQ-026 SHALL last one cycle, then go to FETCH.
REQ-028 Opcode == HALT_OP SHALL enter HALT. halted=1 from the next cycle; HALT is held with all strobes low until rst.
REQ-029 Undefined opcodes SHALL enter HALT with illegal=1 and halted=1.
REQ-030 At most one of wIR, wAR, wM|wR and wPC-with-jmp SHALL be asserted in any cycle, except the combined strobes listed above.
REQ-031 Strobes SHALL decode from the registered state and rIR. Only the gating in REQ-020, REQ-021 and REQ-026 may depend on inputs.

Reset
REQ-032 While rst=1 the state SHALL be FETCH and all outputs 0, including halted and illegal.
REQ-033 A rst asserted in any state, including a WAIT hold or HALT, SHALL abort that state; FETCH is active in the first cycle after rst falls.

Configuration
REQ-034 With HRM_INDIRECT_EN defined, rIR[3]=1 SHALL route through INDIR as in REQ-018.
REQ-035 Without HRM_INDIRECT_EN, the INDIR state SHALL NOT exist and rIR[3] SHALL be ignored, i.e. direct addressing only.

Structure
REQ-036 A shared package SHALL hold the opcode constants, the state encoding, and the srcR and alu_op encodings.
REQ-037 One combinational sub-module, hrm_opdec, SHALL map rIR to has_operand, is_indirect, is_legal and the opcode class.

Verification
REQ-038 rIR=8'h20 then 8'h40, both direct: state sequence is FETCH, DECODE, ARG, EXEC each time; wR=1 with srcR=1, then wR=1 with srcR=2, alu_op=0.
REQ-039 inbox with inbox_empty=1 for 5 cycles, then 0: EXEC held 5 cycles with no strobes; rInbox=1 for exactly one cycle.
REQ-040 jumpz (8'h90) with aluZ=0: no wPC in EXEC. With aluZ=1: wPC=1 and jmp=1 in the same cycle.
REQ-041 rIR=8'hF0: halted=1 and stays 1 for 20 cycles. rIR=8'hB0: illegal=1 and halted=1. rst clears both.
REQ-042 rIR=8'h28 with HRM_INDIRECT_EN: wAR asserted in two consecutive cycles (ARG, INDIR). Without the macro: wAR asserted once.
REQ-043 rst asserted mid-EXEC of bump+: no wM or wR while rst=1; wIR=1 in the first cycle after rst falls.
